arbitro_ffd: RTL

Arbiter and sequencer for a WIDTH-bit bank of ffd master-slave flip-flops shared by two requesters (A, B).
- Grants the bank round-robin and latches the winner's operation.
- Drives the bank's d / pr / clr inputs stable for HOLD cycles so the master-slave pair settles.
- Pulses a one-cycle acknowledge to the winner.
- Sits between requesters and the ffd bank; the bank's q is fed back for hold and readback.

---
 rtl/arbitro_ffd.sv | 91 +++++++++
 1 files changed

// File: rtl/arbitro_ffd.sv
// arbitro_ffd: round-robin arbiter/sequencer driving a shared ffd bank (FFD_VERIFY_EN adds erro readback check)
module arbitro_ffd #(
  parameter int WIDTH = 4,
  parameter int HOLD  = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req_a,
  input  logic [1:0]       op_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [1:0]       op_b,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] bank_q,
  output logic [WIDTH-1:0] bank_d,
  output logic             bank_pr,
  output logic             bank_clr,
  output logic             ack_a,
  output logic             ack_b,
  output logic             busy,
  output logic             owner
`ifdef FFD_VERIFY_EN
  ,
  output logic             erro
`endif
);
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] DRIVE = 2'b01;
  localparam logic [1:0] ACK   = 2'b10;
  localparam logic [1:0] LOAD  = 2'b00;
  localparam logic [1:0] CLR   = 2'b01;
  localparam logic [1:0] PRE   = 2'b10;
  localparam logic [1:0] KEEP  = 2'b11;
  logic [1:0]       state_q, state_d, op_q, op_d;
  logic             ptr_q, ptr_d, owner_q, owner_d, grant, win_b, drv;
  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0]       cnt_q, cnt_d;
  // arbitration and sequencing; the winner's op/data are captured only at the grant edge
  always_comb begin
    grant   = state_q == IDLE && (req_a || req_b);
    win_b   = req_b && (!req_a || ptr_q);
    state_d = grant ? DRIVE : state_q == DRIVE ? (cnt_q == 4'd0 ? ACK : DRIVE) : IDLE;
    ptr_d   = grant ? !win_b : ptr_q;
    owner_d = grant ? win_b : owner_q;
    op_d    = grant ? (win_b ? op_b : op_a) : op_q;
    data_d  = grant ? (win_b ? data_b : data_a) : data_q;
    cnt_d   = grant ? 4'(HOLD - 1) : (state_q == DRIVE && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
  end
  // bank drive: reset forces a clear; outside DRIVE the bank recirculates its own q
  always_comb begin
    drv      = state_q == DRIVE && !clr;
    bank_clr = clr || (drv && op_q == CLR);
    bank_pr  = drv && op_q == PRE;
    bank_d   = clr ? '0 : !drv ? bank_q : op_q == LOAD ? data_q : op_q == PRE ? '1 :
               op_q == CLR ? '0 : bank_q;
    ack_a    = !clr && state_q == ACK && !owner_q;
    ack_b    = !clr && state_q == ACK && owner_q;
    busy     = state_q != IDLE;
    owner    = owner_q;
  end
  // state registers
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      op_q    <= KEEP;
      data_q  <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef FFD_VERIFY_EN
  logic [WIDTH-1:0] exp_q;
  logic             erro_q;
  assign exp_q = op_q == LOAD ? data_q : op_q == PRE ? '1 : '0;
  assign erro  = erro_q;
  // sticky readback mismatch flag, sampled in ACK and cleared by the next grant
  always_ff @(posedge clk) begin
    if (clr) erro_q <= 1'b0;
    else if (grant) erro_q <= 1'b0;
    else if (state_q == ACK && op_q != KEEP && bank_q != exp_q) erro_q <= 1'b1;
  end
`endif
endmodule
